// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: write-back stage exception bus between the pipeline/CP0 side and exc_ctrl.
`timescale 1ns/1ps
interface exc_ctrl_if;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_delay_slot;
  logic [6:0]  wb_exc;
  logic        wb_eret;
  logic [31:0] wb_dm_addr;
  logic [5:0]  hw_int;
  logic [7:0]  status_im;
  logic        status_ie;
  logic        status_exl;
  logic [1:0]  cause_ip_sw;
  logic [31:0] epc_in;
  logic        wb_kill;
  logic        cancel;
  logic        exc_valid;
  logic [31:0] exc_pc;
  logic        cp0_exl_set;
  logic        cp0_exl_clr;
  logic        cp0_cause_we;
  logic [4:0]  cp0_exccode;
  logic        cp0_bd;
  logic        cp0_epc_we;
  logic [31:0] cp0_epc;
  logic        cp0_badv_we;
  logic [31:0] cp0_badvaddr;
  logic [5:0]  hw_ip;
  logic        busy;
  modport master(
    output wb_valid, wb_pc, wb_delay_slot, wb_exc, wb_eret, wb_dm_addr, hw_int,
           status_im, status_ie, status_exl, cause_ip_sw, epc_in,
    input  wb_kill, cancel, exc_valid, exc_pc, cp0_exl_set, cp0_exl_clr, cp0_cause_we,
           cp0_exccode, cp0_bd, cp0_epc_we, cp0_epc, cp0_badv_we, cp0_badvaddr, hw_ip, busy
  );
  modport slave(
    input  wb_valid, wb_pc, wb_delay_slot, wb_exc, wb_eret, wb_dm_addr, hw_int,
           status_im, status_ie, status_exl, cause_ip_sw, epc_in,
    output wb_kill, cancel, exc_valid, exc_pc, cp0_exl_set, cp0_exl_clr, cp0_cause_we,
           cp0_exccode, cp0_bd, cp0_epc_we, cp0_epc, cp0_badv_we, cp0_badvaddr, hw_ip, busy
  );
endinterface

// File: rtl/exc_ctrl.sv
// exc_ctrl: WB-stage exception/interrupt sequencer with CP0 strobes and flush/redirect FSM.
`timescale 1ns/1ps
module exc_ctrl #(
  parameter logic [31:0] EXC_ENTER_ADDR = 32'hBFC00380,
  parameter int          FLUSH_CYCLES   = 2,
  parameter int          SYNC_STAGES    = 2
) (
  input logic       clk,
  input logic       reset,
  exc_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, TRAP, DRAIN, REDIRECT} state_t;
  state_t      state;
  logic [5:0]  sync [SYNC_STAGES];
  logic [3:0]  cnt;
  logic        int_req, any_exc, accept, badv_hit;
  logic [4:0]  code;
  logic [6:0]  e;
  assign e = bus.wb_exc;
  assign bus.hw_ip = sync[SYNC_STAGES-1];
  always_comb begin
    int_req = |({bus.hw_ip, bus.cause_ip_sw} & bus.status_im) & bus.status_ie & ~bus.status_exl;
    any_exc = int_req | (|e);
    accept = (state == IDLE) & bus.wb_valid & (any_exc | bus.wb_eret);
    bus.wb_kill = (state == IDLE) & bus.wb_valid & any_exc;
    code = int_req ? 5'd0 : e[6] ? 5'd4 : e[5] ? 5'd10 : e[4] ? 5'd12 :
           e[3] ? 5'd8 : e[2] ? 5'd9 : e[1] ? 5'd4 : 5'd5;
    badv_hit = ~int_req & (e[6] | ((e[5:2] == 4'b0) & (|e[1:0])));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
      bus.cancel <= 1'b0;
      bus.exc_valid <= 1'b0;
      bus.exc_pc <= '0;
      bus.cp0_exl_set <= 1'b0;
      bus.cp0_exl_clr <= 1'b0;
      bus.cp0_cause_we <= 1'b0;
      bus.cp0_exccode <= '0;
      bus.cp0_bd <= 1'b0;
      bus.cp0_epc_we <= 1'b0;
      bus.cp0_epc <= '0;
      bus.cp0_badv_we <= 1'b0;
      bus.cp0_badvaddr <= '0;
      bus.busy <= 1'b0;
    end else begin
      sync[0] <= bus.hw_int;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      case (state)
        IDLE: if (accept) begin
          state <= TRAP;
          bus.busy <= 1'b1;
          bus.cancel <= 1'b1;
          // redirect target is captured now so a later EPC write cannot disturb ERET
          bus.exc_pc <= any_exc ? EXC_ENTER_ADDR : bus.epc_in;
          bus.cp0_exl_set <= any_exc;
          bus.cp0_exl_clr <= ~any_exc;
          bus.cp0_cause_we <= any_exc;
          bus.cp0_exccode <= code;
          bus.cp0_bd <= any_exc & ~bus.status_exl & bus.wb_delay_slot;
          bus.cp0_epc_we <= any_exc & ~bus.status_exl;
          bus.cp0_epc <= bus.wb_delay_slot ? bus.wb_pc - 32'd4 : bus.wb_pc;
          bus.cp0_badv_we <= any_exc & badv_hit;
          bus.cp0_badvaddr <= e[6] ? bus.wb_pc : bus.wb_dm_addr;
        end
        TRAP: begin
          state <= DRAIN;
          cnt <= 4'(FLUSH_CYCLES - 1);
          bus.cp0_exl_set <= 1'b0;
          bus.cp0_exl_clr <= 1'b0;
          bus.cp0_cause_we <= 1'b0;
          bus.cp0_epc_we <= 1'b0;
          bus.cp0_badv_we <= 1'b0;
        end
        DRAIN: if (cnt == '0) begin
          state <= REDIRECT;
          bus.cancel <= 1'b0;
          bus.exc_valid <= 1'b1;
        end else cnt <= cnt - 4'd1;
        REDIRECT: begin
          state <= IDLE;
          bus.exc_valid <= 1'b0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed scenario tests for exc_ctrl.
`timescale 1ns/1ps
module tb_exc_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0, bad = 0;
  exc_ctrl_if bus();
  exc_ctrl dut(.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;

  logic        k_idle, k_busy, t_set, t_clr, t_cause, t_bd, t_epc_we, t_badv_we, end_busy;
  logic [4:0]  t_code;
  logic [31:0] t_epc, t_badv, v_pc;
  int          n_cancel, n_valid, n_set;

  task automatic fire(input logic [31:0] pc, input logic ds, input logic [6:0] exc,
                      input logic eret, input logic [31:0] dm, input logic [31:0] epc,
                      input logic exl);
    @(negedge clk);
    bus.wb_valid = 1'b1; bus.wb_pc = pc; bus.wb_delay_slot = ds; bus.wb_exc = exc;
    bus.wb_eret = eret; bus.wb_dm_addr = dm; bus.epc_in = epc; bus.status_exl = exl;
    #1 k_idle = bus.wb_kill;
    @(posedge clk); #1;
    t_set = bus.cp0_exl_set; t_clr = bus.cp0_exl_clr; t_cause = bus.cp0_cause_we;
    t_code = bus.cp0_exccode; t_bd = bus.cp0_bd; t_epc_we = bus.cp0_epc_we; t_epc = bus.cp0_epc;
    t_badv_we = bus.cp0_badv_we; t_badv = bus.cp0_badvaddr; k_busy = bus.wb_kill;
    bus.wb_valid = 1'b0; bus.wb_exc = '0; bus.wb_eret = 1'b0;
    n_cancel = int'(bus.cancel); n_set = int'(bus.cp0_exl_set); n_valid = 0; v_pc = '0;
    repeat (8) begin
      @(posedge clk); #1;
      n_cancel += int'(bus.cancel);
      n_set += int'(bus.cp0_exl_set);
      if (bus.exc_valid) begin n_valid++; v_pc = bus.exc_pc; end
    end
    end_busy = bus.busy;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.cancel !== 1'b0) begin bad++; $display("FAIL reset_cancel got=%b exp=0", bus.cancel); end
    total++; if (bus.exc_valid !== 1'b0) begin bad++; $display("FAIL reset_exc_valid got=%b exp=0", bus.exc_valid); end
    total++; if (bus.exc_pc !== 32'h0) begin bad++; $display("FAIL reset_exc_pc got=%h exp=0", bus.exc_pc); end
    total++; if (bus.cp0_epc !== 32'h0) begin bad++; $display("FAIL reset_epc got=%h exp=0", bus.cp0_epc); end
    total++; if (bus.hw_ip !== 6'h0) begin bad++; $display("FAIL reset_hw_ip got=%h exp=0", bus.hw_ip); end
    reset = 1'b0;
  endtask

  task automatic test_syscall;
    fire(32'h0040_0010, 1'b0, 7'b0001000, 1'b0, 32'h0, 32'h0, 1'b0);
    total++; if (k_idle !== 1'b1) begin bad++; $display("FAIL sys_kill got=%b exp=1", k_idle); end
    total++; if (k_busy !== 1'b0) begin bad++; $display("FAIL sys_kill_busy got=%b exp=0", k_busy); end
    total++; if (t_code !== 5'd8) begin bad++; $display("FAIL sys_code got=%0d exp=8", t_code); end
    total++; if (t_epc_we !== 1'b1 || t_epc !== 32'h0040_0010) begin bad++; $display("FAIL sys_epc got=%b/%h exp=1/00400010", t_epc_we, t_epc); end
    total++; if (t_bd !== 1'b0) begin bad++; $display("FAIL sys_bd got=%b exp=0", t_bd); end
    total++; if (t_set !== 1'b1 || t_clr !== 1'b0 || t_cause !== 1'b1) begin bad++; $display("FAIL sys_strobes got=%b%b%b exp=101", t_set, t_clr, t_cause); end
    total++; if (t_badv_we !== 1'b0) begin bad++; $display("FAIL sys_badv_we got=%b exp=0", t_badv_we); end
    total++; if (n_cancel !== 3) begin bad++; $display("FAIL sys_cancel_cycles got=%0d exp=3", n_cancel); end
    total++; if (n_set !== 1) begin bad++; $display("FAIL sys_exl_set_cycles got=%0d exp=1", n_set); end
    total++; if (n_valid !== 1 || v_pc !== 32'hBFC0_0380) begin bad++; $display("FAIL sys_redirect got=%0d/%h exp=1/bfc00380", n_valid, v_pc); end
    total++; if (end_busy !== 1'b0) begin bad++; $display("FAIL sys_idle got=%b exp=0", end_busy); end
  endtask

  task automatic test_priority;
    fire(32'h0000_0100, 1'b1, 7'b0010010, 1'b0, 32'h0000_5555, 32'h0, 1'b0);
    total++; if (t_code !== 5'd12) begin bad++; $display("FAIL ov_code got=%0d exp=12", t_code); end
    total++; if (t_epc !== 32'h0000_00FC || t_bd !== 1'b1) begin bad++; $display("FAIL ov_epc_bd got=%h/%b exp=000000fc/1", t_epc, t_bd); end
    total++; if (t_badv_we !== 1'b0) begin bad++; $display("FAIL ov_badv_we got=%b exp=0", t_badv_we); end
    fire(32'h0000_2000, 1'b0, 7'b1001000, 1'b0, 32'h0000_7777, 32'h0, 1'b0);
    total++; if (t_code !== 5'd4) begin bad++; $display("FAIL fetch_code got=%0d exp=4", t_code); end
    total++; if (t_badv_we !== 1'b1 || t_badv !== 32'h0000_2000) begin bad++; $display("FAIL fetch_badv got=%b/%h exp=1/00002000", t_badv_we, t_badv); end
    fire(32'h0000_3000, 1'b0, 7'b0100100, 1'b0, 32'h0, 32'h0, 1'b0);
    total++; if (t_code !== 5'd10) begin bad++; $display("FAIL rsv_code got=%0d exp=10", t_code); end
    fire(32'h0000_3004, 1'b0, 7'b0000100, 1'b0, 32'h0, 32'h0, 1'b0);
    total++; if (t_code !== 5'd9) begin bad++; $display("FAIL break_code got=%0d exp=9", t_code); end
    fire(32'h0000_3008, 1'b0, 7'b0000011, 1'b0, 32'h0000_1001, 32'h0, 1'b0);
    total++; if (t_code !== 5'd4 || t_badv !== 32'h0000_1001) begin bad++; $display("FAIL raddr got=%0d/%h exp=4/00001001", t_code, t_badv); end
  endtask

  task automatic test_interrupt;
    @(negedge clk);
    bus.hw_int = 6'b000001; bus.status_im = 8'h04; bus.status_ie = 1'b1; bus.status_exl = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.hw_ip !== 6'h00) begin bad++; $display("FAIL int_sync1 got=%h exp=00", bus.hw_ip); end
    @(posedge clk); #1;
    total++; if (bus.hw_ip !== 6'h01) begin bad++; $display("FAIL int_sync2 got=%h exp=01", bus.hw_ip); end
    fire(32'h0040_0040, 1'b0, 7'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    total++; if (k_idle !== 1'b1) begin bad++; $display("FAIL int_kill got=%b exp=1", k_idle); end
    total++; if (t_code !== 5'd0 || t_epc !== 32'h0040_0040) begin bad++; $display("FAIL int_cause got=%0d/%h exp=0/00400040", t_code, t_epc); end
    total++; if (n_valid !== 1 || v_pc !== 32'hBFC0_0380) begin bad++; $display("FAIL int_redirect got=%0d/%h exp=1/bfc00380", n_valid, v_pc); end
    @(negedge clk);
    bus.status_ie = 1'b0; bus.wb_valid = 1'b1;
    #1;
    total++; if (bus.wb_kill !== 1'b0) begin bad++; $display("FAIL int_ie0_kill got=%b exp=0", bus.wb_kill); end
    @(posedge clk); #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL int_ie0_busy got=%b exp=0", bus.busy); end
    bus.wb_valid = 1'b0; bus.hw_int = 6'b0; bus.status_im = 8'h00;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_eret;
    fire(32'h0040_0300, 1'b0, 7'b0, 1'b1, 32'h0, 32'h0040_0200, 1'b1);
    total++; if (k_idle !== 1'b0) begin bad++; $display("FAIL eret_kill got=%b exp=0", k_idle); end
    total++; if (t_clr !== 1'b1 || t_set !== 1'b0) begin bad++; $display("FAIL eret_exl got=clr%b set%b exp=clr1 set0", t_clr, t_set); end
    total++; if (t_cause !== 1'b0 || t_epc_we !== 1'b0 || t_badv_we !== 1'b0) begin bad++; $display("FAIL eret_writes got=%b%b%b exp=000", t_cause, t_epc_we, t_badv_we); end
    total++; if (n_valid !== 1 || v_pc !== 32'h0040_0200) begin bad++; $display("FAIL eret_redirect got=%0d/%h exp=1/00400200", n_valid, v_pc); end
  endtask

  task automatic test_addr_err;
    fire(32'h0000_4000, 1'b1, 7'b0000001, 1'b0, 32'h0000_1003, 32'h0, 1'b1);
    total++; if (t_code !== 5'd5) begin bad++; $display("FAIL waddr_code got=%0d exp=5", t_code); end
    total++; if (t_badv_we !== 1'b1 || t_badv !== 32'h0000_1003) begin bad++; $display("FAIL waddr_badv got=%b/%h exp=1/00001003", t_badv_we, t_badv); end
    total++; if (t_epc_we !== 1'b0 || t_bd !== 1'b0) begin bad++; $display("FAIL waddr_exl_epc got=%b/%b exp=0/0", t_epc_we, t_bd); end
    total++; if (t_set !== 1'b1 || t_cause !== 1'b1) begin bad++; $display("FAIL waddr_strobes got=%b%b exp=11", t_set, t_cause); end
    fire(32'h0000_0000, 1'b1, 7'b0000100, 1'b0, 32'h0, 32'h0, 1'b0);
    total++; if (t_epc !== 32'hFFFF_FFFC || t_bd !== 1'b1) begin bad++; $display("FAIL wrap_epc got=%h/%b exp=fffffffc/1", t_epc, t_bd); end
  endtask

  task automatic test_reset_mid_flush;
    @(negedge clk);
    bus.wb_valid = 1'b1; bus.wb_pc = 32'h0040_0060; bus.wb_delay_slot = 1'b0;
    bus.wb_exc = 7'b0001000; bus.status_exl = 1'b0;
    @(posedge clk); #1;
    bus.wb_valid = 1'b0; bus.wb_exc = '0;
    @(posedge clk); #1;
    total++; if (bus.cancel !== 1'b1) begin bad++; $display("FAIL rmf_drain_cancel got=%b exp=1", bus.cancel); end
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.busy !== 1'b0 || bus.cancel !== 1'b0) begin bad++; $display("FAIL rmf_reset got=busy%b cancel%b exp=0/0", bus.busy, bus.cancel); end
    reset = 1'b0;
    n_valid = 0;
    repeat (6) begin @(posedge clk); #1; n_valid += int'(bus.exc_valid); end
    total++; if (n_valid !== 0) begin bad++; $display("FAIL rmf_no_redirect got=%0d exp=0", n_valid); end
    fire(32'h0040_0080, 1'b0, 7'b0001000, 1'b0, 32'h0, 32'h0, 1'b0);
    total++; if (t_code !== 5'd8 || t_epc !== 32'h0040_0080) begin bad++; $display("FAIL rmf_new_sys got=%0d/%h exp=8/00400080", t_code, t_epc); end
    total++; if (n_cancel !== 3 || n_valid !== 1) begin bad++; $display("FAIL rmf_new_flush got=%0d/%0d exp=3/1", n_cancel, n_valid); end
  endtask

  initial begin
    bus.wb_valid = 1'b0; bus.wb_pc = '0; bus.wb_delay_slot = 1'b0; bus.wb_exc = '0;
    bus.wb_eret = 1'b0; bus.wb_dm_addr = '0; bus.hw_int = '0; bus.status_im = '0;
    bus.status_ie = 1'b0; bus.status_exl = 1'b0; bus.cause_ip_sw = '0; bus.epc_in = '0;
    test_reset;
    test_syscall;
    test_priority;
    test_interrupt;
    test_eret;
    test_addr_err;
    test_reset_mid_flush;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
